// File: rtl/q_add.sv
// Registered sign-magnitude fixed-point adder with one-cycle latency.
// Magnitude overflow saturates to full scale and raises ovf; zero results are always +0.
module q_add #(
  parameter int Q = 19,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         out_valid,
  output logic         ovf
);

  // Q only sets where the binary point sits; the arithmetic never looks at it.
  logic [31:0] unused_q;
  assign unused_q = Q;

  logic         sa;
  logic         sb;
  logic [N-2:0] ma;
  logic [N-2:0] mb;
  logic [N-1:0] sum;
  logic [N-2:0] res_mag;
  logic         res_sign;
  logic         res_ovf;

  logic [N-1:0] c_d;
  logic [N-1:0] c_q;
  logic         ovf_d;
  logic         ovf_q;
  logic         out_valid_d;
  logic         out_valid_q;

  assign sa = a[N-1];
  assign sb = b[N-1];
  assign ma = a[N-2:0];
  assign mb = b[N-2:0];

  always_comb begin
    sum      = {1'b0, ma} + {1'b0, mb};
    res_mag  = '0;
    res_sign = 1'b0;
    res_ovf  = 1'b0;

    if (sa == sb) begin
      res_sign = sa;
      if (sum[N-1]) begin
        res_mag = '1;
        res_ovf = 1'b1;
      end else begin
        res_mag = sum[N-2:0];
      end
    end else if (ma >= mb) begin
      res_mag  = ma - mb;
      res_sign = sa;
    end else begin
      res_mag  = mb - ma;
      res_sign = sb;
    end

    // Cancellation and -0 operands must never leave a negative zero behind.
    if (res_mag == '0) begin
      res_sign = 1'b0;
    end

    c_d         = c_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      c_d   = {res_sign, res_mag};
      ovf_d = res_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c         = c_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_q_add.sv
// Scoreboard bench for q_add: stimulus pushes expected results computed from
// signed-integer arithmetic, and a monitor pops and compares one cycle later.
module tb_q_add;

  localparam int N = 32;
  localparam int Q = 19;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic         out_valid;
  logic         ovf;

  typedef struct {
    logic [N-1:0] c;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] last_c = '0;
  logic         last_ovf = 1'b0;

  q_add #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: interpret both words as signed reals-in-LSBs, add, clamp to
  // the largest representable magnitude, and re-encode with +0 for zero.
  function automatic void refModel(input logic [N-1:0] x, input logic [N-1:0] y,
                                   output logic [N-1:0] r, output logic o);
    longint vx, vy, s, full;
    logic [N-2:0] mag;
    full = (longint'(1) <<< (N - 1)) - 1;
    vx = longint'(x[N-2:0]);
    vy = longint'(y[N-2:0]);
    if (x[N-1]) vx = -vx;
    if (y[N-1]) vy = -vy;
    s = vx + vy;
    o = 1'b0;
    if (s > full) begin s = full; o = 1'b1; end
    if (s < -full) begin s = -full; o = 1'b1; end
    mag = (s < 0) ? N'(-s) : N'(s);
    r = {(s < 0), mag};
  endfunction

  task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    refModel(x, y, e.c, e.ovf);
    e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Monitor: every cycle either a result is due (and must be presented) or
  // nothing is due and the outputs must hold with out_valid low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        last_c = '0;
        last_ovf = 1'b0;
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checkOutput("out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("c", c, e.c);
        checkOutput("ovf", {31'b0, ovf}, {31'b0, e.ovf});
        last_c = e.c;
        last_ovf = e.ovf;
      end else begin
        checkOutput("out_valid_idle", {31'b0, out_valid}, 32'd0);
        checkOutput("c_hold", c, last_c);
        checkOutput("ovf_hold", {31'b0, ovf}, {31'b0, last_ovf});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint sw_a, sw_b;
    logic [N-1:0] x, y;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    #1;
    checkOutput("reset_c", c, 32'h0);
    checkOutput("reset_ovf", {31'b0, ovf}, 32'd0);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();

    // Directed vectors from the Q19 worked examples
    applyStimulus(32'h00080000, 32'h80100000);
    applyStimulus(32'h000C0000, 32'h00120000);
    applyStimulus(32'h800C0000, 32'h80120000);
    applyStimulus(32'h00080000, 32'h80080000);
    applyStimulus(32'h00001234, 32'h80000000);
    applyStimulus(32'h80000000, 32'h80000000);
    applyStimulus(32'h7FFFFFFF, 32'h00000001);
    applyStimulus(32'hC0000000, 32'hC0000000);
    idle();
    idle();
    applyStimulus(32'h7FFFFFFF, 32'h80000001);
    applyStimulus(32'h40000000, 32'h3FFFFFFF);
    applyStimulus(32'h80000005, 32'h00000007);
    idle();

    // Sweep: a climbs from +0, b grows negative each time a wraps
    sw_a = 0;
    sw_b = 0;
    for (int i = 0; i < 1300; i++) begin
      x = {1'b0, sw_a[N-2:0]};
      y = {1'b1, sw_b[N-2:0]};
      applyStimulus(x, y);
      sw_a = sw_a + 5179347;
      if (sw_a > 64'd2100000000) begin
        sw_a = 0;
        sw_b = sw_b + 3779351;
      end
    end
    idle();

    // Random operands with random gaps; bias some toward extremes and ties
    for (int i = 0; i < 400; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 4))
        0: y = {~x[N-1], x[N-2:0]};
        1: x = {x[N-1], 31'h7FFFFFF0 | x[3:0]};
        2: y = {y[N-1], 31'h0};
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) idle();
      applyStimulus(x, y);
    end

    // Mid-stream reset: asserted between edges while a result is showing
    applyStimulus(32'h00123456, 32'h00010000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("async_reset_c", c, 32'h0);
    checkOutput("async_reset_ovf", {31'b0, ovf}, 32'd0);
    checkOutput("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1;
    a = 32'h7FFFFFFF;
    b = 32'h7FFFFFFF;
    @(posedge clk);
    #1;
    checkOutput("in_reset_c", c, 32'h0);
    checkOutput("in_reset_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    applyStimulus(32'h00080000, 32'h00080000);
    applyStimulus(32'h80000001, 32'h00000001);
    idle();
    repeat (3) idle();

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
